// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin share of the common data bus among five FUs.
// Ports: clk, rst (sync, active-low), flush, fu_valid/fu_payload/fu_ready
//   per unit; cdb_valid/cdb_payload/cdb_src to consumers; grant_cnt and
//   contention_cnt statistics.
package cdb_pkg;
  typedef struct packed {
    logic [5:0]  rob_id;
    logic [31:0] data;
    logic        br_miss;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] pc_next;
  } cdb_output_t;
endpackage

module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_FU    = 5,
  parameter int PAYLOAD_W = $bits(cdb_output_t),
  localparam int SW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [NUM_FU-1:0]           fu_valid,
  input  logic [NUM_FU*PAYLOAD_W-1:0] fu_payload,
  output logic [NUM_FU-1:0]           fu_ready,
  output logic                        cdb_valid,
  output logic [PAYLOAD_W-1:0]        cdb_payload,
  output logic [SW-1:0]               cdb_src,
  output logic [31:0]                 grant_cnt,
  output logic [31:0]                 contention_cnt
);

  logic [NUM_FU-1:0]    buf_v_q, buf_v_d;
  logic [PAYLOAD_W-1:0] buf_d_q [NUM_FU];
  logic [PAYLOAD_W-1:0] buf_d_d [NUM_FU];
  logic [SW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [31:0]          gcnt_q, gcnt_d;
  logic [31:0]          ccnt_q, ccnt_d;

  logic [NUM_FU-1:0] grant;
  logic [SW-1:0]     g;
  logic              found;
  logic [NUM_FU-1:0] cap;
  logic              multi;
  int                idx;

  // Rotating search starting at rr_ptr; NUM_FU need not be a power of two.
  always_comb begin
    grant = '0;
    g     = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_FU; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_FU) idx = idx - NUM_FU;
      if (!found && buf_v_q[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        g          = SW'(idx);
      end
    end
    if (flush || !rst) begin
      grant = '0;
      g     = '0;
      found = 1'b0;
    end
  end

  assign cdb_valid   = found;
  assign cdb_src     = g;
  assign cdb_payload = found ? buf_d_q[g] : '0;
  assign fu_ready    = {NUM_FU{rst}}
                     & (~buf_v_q | grant | {NUM_FU{flush}});
  assign grant_cnt      = gcnt_q;
  assign contention_cnt = ccnt_q;

  assign cap = fu_valid & fu_ready & {NUM_FU{~flush}};
  // Two or more bits set iff clearing the lowest set bit leaves any.
  assign multi = (buf_v_q & (buf_v_q - NUM_FU'(1))) != '0;

  always_comb begin
    buf_v_d = buf_v_q;
    for (int i = 0; i < NUM_FU; i++) begin
      buf_d_d[i] = buf_d_q[i];
      if (cap[i]) begin
        buf_v_d[i] = 1'b1;
        buf_d_d[i] = fu_payload[i*PAYLOAD_W +: PAYLOAD_W];
      end else if (grant[i] || flush) begin
        buf_v_d[i] = 1'b0;
      end
    end
    rr_ptr_d = rr_ptr_q;
    if (found)
      rr_ptr_d = (int'(g) == NUM_FU - 1) ? '0 : g + SW'(1);
    gcnt_d = gcnt_q + 32'(found);
    ccnt_d = ccnt_q;
    if (multi && !flush && ccnt_q != '1)
      ccnt_d = ccnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      buf_v_q  <= '0;
      rr_ptr_q <= '0;
      gcnt_q   <= '0;
      ccnt_q   <= '0;
      for (int i = 0; i < NUM_FU; i++)
        buf_d_q[i] <= '0;
    end else begin
      buf_v_q  <= buf_v_d;
      rr_ptr_q <= rr_ptr_d;
      gcnt_q   <= gcnt_d;
      ccnt_q   <= ccnt_d;
      for (int i = 0; i < NUM_FU; i++)
        buf_d_q[i] <= buf_d_d[i];
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed plus random stimulus for cdb_arbiter,
// compared each cycle against a queue/array model of the bus rules.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  localparam int N  = 5;
  localparam int PW = $bits(cdb_output_t);

  logic            clk = 0;
  logic            rst = 0;
  logic            flush = 0;
  logic [N-1:0]    fu_valid = '0;
  logic [N*PW-1:0] fu_payload = '0;
  logic [N-1:0]    fu_ready;
  logic            cdb_valid;
  logic [PW-1:0]   cdb_payload;
  logic [2:0]      cdb_src;
  logic [31:0]     grant_cnt;
  logic [31:0]     contention_cnt;

  cdb_arbiter dut (
    .clk(clk), .rst(rst), .flush(flush),
    .fu_valid(fu_valid), .fu_payload(fu_payload),
    .fu_ready(fu_ready), .cdb_valid(cdb_valid),
    .cdb_payload(cdb_payload), .cdb_src(cdb_src),
    .grant_cnt(grant_cnt), .contention_cnt(contention_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Producer side: each unit holds its offer until it is accepted.
  bit            pend [N];
  logic [PW-1:0] pay  [N];

  // Reference: one optional entry per unit, pointer, counters.
  bit            mv [N];
  logic [PW-1:0] md [N];
  int            rr;
  logic [31:0]   gcnt, ccnt;
  int            mg;
  bit            mrdy [N];
  int            last_src;

  task automatic check(string tag, logic [127:0] got,
                       logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] rnd_pay();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[PW-1:0];
  endfunction

  function automatic logic [PW-1:0] rob_pay(int id);
    cdb_output_t p;
    p = cdb_output_t'(rnd_pay());
    p.rob_id = 6'(id);
    return PW'(p);
  endfunction

  task automatic model_outputs();
    logic [N-1:0] er;
    mg = -1;
    if (rst && !flush)
      for (int k = 0; k < N; k++)
        if (mg < 0 && mv[(rr + k) % N]) mg = (rr + k) % N;
    for (int i = 0; i < N; i++) begin
      mrdy[i] = rst && (!mv[i] || mg == i || flush);
      er[i]   = mrdy[i];
    end
    check("ready", fu_ready, er);
    check("valid", cdb_valid, mg >= 0);
    check("src", cdb_src, mg >= 0 ? mg : 0);
    check("payload", cdb_payload, mg >= 0 ? md[mg] : '0);
    check("grant_cnt", grant_cnt, gcnt);
    check("cont_cnt", contention_cnt, ccnt);
  endtask

  task automatic model_edge();
    int occ;
    if (!rst) begin
      for (int i = 0; i < N; i++) mv[i] = 0;
      rr = 0; gcnt = 0; ccnt = 0;
      return;
    end
    occ = 0;
    for (int i = 0; i < N; i++) occ += int'(mv[i]);
    if (occ >= 2 && !flush && ccnt != 32'hFFFF_FFFF) ccnt++;
    if (mg >= 0) begin
      gcnt++;
      rr = (mg + 1) % N;
    end
    for (int i = 0; i < N; i++) begin
      if (fu_valid[i] && mrdy[i] && !flush) begin
        mv[i] = 1;
        md[i] = pay[i];
      end else if (mg == i || flush) begin
        mv[i] = 0;
      end
    end
  endtask

  // One cycle: drive at negedge, check 1ns later, advance model at posedge.
  task automatic cycle(bit r, bit f);
    @(negedge clk);
    rst = r;
    flush = f;
    for (int i = 0; i < N; i++) begin
      fu_valid[i] = pend[i];
      fu_payload[i*PW +: PW] = pay[i];
    end
    #1;
    model_outputs();
    last_src = mg;
    @(posedge clk);
    model_edge();
    for (int i = 0; i < N; i++)
      if (mrdy[i]) pend[i] = 0;
  endtask

  task automatic offer(int u, logic [PW-1:0] p);
    pend[u] = 1;
    pay[u] = p;
  endtask

  initial begin
    cdb_output_t seen;
    int prev, maxgap, gap4, gap0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 0; pay[i] = '0; mv[i] = 0; md[i] = '0;
    end
    rr = 0; gcnt = 0; ccnt = 0;

    // Reset state.
    cycle(0, 0);
    cycle(0, 0);
    check("rst_cdb_valid", cdb_valid, 0);

    // Single result from unit 2 with rob id 5.
    offer(2, rob_pay(5));
    cycle(1, 0);
    check("single_ready2", fu_ready[2], 1);
    cycle(1, 0);
    seen = cdb_output_t'(cdb_payload);
    check("single_src", cdb_src, 2);
    check("single_rob", seen.rob_id, 5);
    cycle(1, 0);
    check("single_gcnt", grant_cnt, 1);
    check("single_idle", cdb_valid, 0);

    // All five offer together from rr_ptr=0.
    cycle(0, 0);
    for (int i = 0; i < N; i++) offer(i, rob_pay(10 + i));
    cycle(1, 0);
    for (int i = 0; i < N; i++) begin
      cycle(1, 0);
      check("simul_order", cdb_src, i);
    end
    cycle(1, 0);
    check("simul_cont", contention_cnt, 4);
    // rr_ptr wrapped to 0: unit 0 beats unit 1 next.
    offer(1, rnd_pay());
    offer(0, rnd_pay());
    cycle(1, 0);
    cycle(1, 0);
    check("simul_wrap", cdb_src, 0);
    repeat (2) cycle(1, 0);

    // Fairness: units 0 and 4 re-offer continuously.
    prev = -1; maxgap = 0; gap0 = 0; gap4 = 0;
    for (int c = 0; c < 12; c++) begin
      if (!pend[0]) offer(0, rnd_pay());
      if (!pend[4]) offer(4, rnd_pay());
      cycle(1, 0);
      if (c >= 2) begin
        gap0 = (last_src == 0) ? 0 : gap0 + 1;
        gap4 = (last_src == 4) ? 0 : gap4 + 1;
        if (gap0 > maxgap) maxgap = gap0;
        if (gap4 > maxgap) maxgap = gap4;
        if (prev >= 0) check("fair_alt", last_src != prev, 1);
        prev = last_src;
      end
    end
    check("fair_gap", maxgap <= 1, 1);
    repeat (3) cycle(1, 0);

    // Backpressure: units 1 and 3 occupied, pointer on 3.
    cycle(0, 0);
    offer(2, rnd_pay());
    cycle(1, 0);
    cycle(1, 0);
    offer(1, rob_pay(21));
    offer(3, rob_pay(23));
    cycle(1, 0);
    offer(1, rob_pay(22));
    cycle(1, 0);
    check("bp_ready1", fu_ready[1], 0);
    check("bp_src3", cdb_src, 3);
    cycle(1, 0);
    seen = cdb_output_t'(cdb_payload);
    check("bp_first", seen.rob_id, 21);
    check("bp_ready1_g", fu_ready[1], 1);
    cycle(1, 0);
    seen = cdb_output_t'(cdb_payload);
    check("bp_second", seen.rob_id, 22);

    // Flush with three occupied buffers while unit 0 offers.
    offer(1, rnd_pay()); offer(2, rnd_pay()); offer(3, rnd_pay());
    cycle(1, 0);
    offer(0, rob_pay(40));
    cycle(1, 1);
    check("fl_valid", cdb_valid, 0);
    check("fl_ready0", fu_ready[0], 1);
    cycle(1, 0);
    check("fl_empty", cdb_valid, 0);
    check("fl_ready", fu_ready, 5'b11111);

    // Reset mid-stream with two occupied buffers.
    offer(0, rnd_pay()); offer(4, rnd_pay());
    cycle(1, 0);
    cycle(0, 0);
    check("rm_ready", fu_ready, 0);
    check("rm_valid", cdb_valid, 0);
    cycle(1, 0);
    check("rm_gcnt", grant_cnt, 0);
    check("rm_empty", cdb_valid, 0);
    offer(3, rob_pay(7));
    cycle(1, 0);
    cycle(1, 0);
    check("rm_lat", cdb_src, 3);

    // Random traffic with occasional flush and reset.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 3) != 0)
          offer(i, rnd_pay());
      cycle($urandom_range(0, 99) >= 2, $urandom_range(0, 99) < 3);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Shares the single common data bus (CDB) feeding the reorder buffer, reservation stations and physical register file among the five functional units: arith, mult, mem, br and div. Each unit owns a one-entry holding buffer. A round-robin scheduler grants one occupied buffer per cycle onto the CDB. A flush from the reorder buffer discards all buffered results, and the block keeps contention statistics for performance debug.

## Interface
- NUM_FU, default 5: number of requesters. Index order is 0 arith, 1 mult, 2 mem, 3 br, 4 div.
- PAYLOAD_W, default $bits(cdb_output_t): opaque width of one CDB result (rob id, data, br_miss, mem fields, pc_next).
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset; rst==0 at a rising edge resets the block.
- flush  in  1  misprediction flush from the reorder buffer.
- fu_valid  in  NUM_FU  result offered by unit i.
- fu_payload  in  NUM_FU*PAYLOAD_W  result of unit i in slice i.
- fu_ready  out  NUM_FU  unit i's offer is accepted this cycle.
- cdb_valid  out  1  CDB carries a result this cycle.
- cdb_payload  out  PAYLOAD_W  granted result.
- cdb_src  out  $clog2(NUM_FU)  index of the granted unit.
- grant_cnt  out  32  total grants, wraps modulo 2^32.
- contention_cnt  out  32  cycles with 2 or more occupied buffers, saturates at 32'hFFFF_FFFF.

## Operation
- State:
  - buf_v[i] and buf_d[i] for each unit.
  - rr_ptr, width $clog2(NUM_FU).
  - the two counters.
- Arbitration (combinational on buffer state):
  - Search i = rr_ptr, rr_ptr+1, … modulo NUM_FU. The first i with buf_v[i]=1 is granted.
  - Grant is one-hot or zero. It is forced to zero while flush=1 or rst=0.
- CDB drive:
  - cdb_valid = (grant != 0).
  - cdb_payload = buf_d[g] and cdb_src = g, where g is the granted index.
  - When cdb_valid=0, cdb_payload and cdb_src are driven to zero.
- Ready: fu_ready[i] = rst & (~buf_v[i] | grant[i] | flush).
- Capture at each edge, when fu_valid[i] & fu_ready[i] & ~flush:
  - buf_v[i] <= 1, buf_d[i] <= payload slice i.
  - If instead grant[i] or flush, buf_v[i] <= 0.
  - If both capture and grant[i] occur, capture wins: the granted entry leaves and the new one enters the same cycle.
- Pointer:
  - On a grant of g, rr_ptr <= (g+1) mod NUM_FU, with explicit wrap since NUM_FU is not a power of two.
  - No grant leaves rr_ptr unchanged.
  - Flush leaves rr_ptr unchanged.
- Counters:
  - grant_cnt increments on every cdb_valid cycle.
  - contention_cnt increments when popcount(buf_v) >= 2 and flush=0.
- Flush:
  - All buf_v clear at the edge.
  - Offers made during the flush cycle are acknowledged (fu_ready=1) and dropped.
  - No CDB output occurs in the flush cycle.
- The block never reorders results from one unit. Each unit has at most one outstanding entry.

## Timing
- Reset (rst=0 at an edge):
  - buf_v all 0, rr_ptr 0, grant_cnt 0, contention_cnt 0.
  - While rst=0: fu_ready all 0, cdb_valid 0, cdb_payload 0, cdb_src 0.
  - Reset asserted mid-operation discards every buffered result at that edge, with no CDB output.
- Latency: an offer accepted at edge N appears on the CDB no earlier than the cycle after edge N. Zero-latency bypass does not exist.
- Worst-case wait for an occupied buffer is NUM_FU-1 grant cycles (fairness bound).
- Backpressure: a unit whose buffer is occupied and not granted sees fu_ready=0. It must hold fu_valid and fu_payload stable until accepted.
- Full throughput: one result per cycle per unit, provided that unit is granted every cycle.
- All outputs are combinational from registered state plus flush/rst/fu_valid. No combinational path exists from fu_payload to cdb_payload.

## Test plan
- Single result:
  - Stimulus: after reset, unit 2 offers rob id 5 at cycle 1.
  - Required: fu_ready[2]=1 at cycle 1; cdb_valid=1 with cdb_src=2 and rob id 5 at cycle 2; rr_ptr=3 afterward; grant_cnt=1.
- Simultaneous offers:
  - Stimulus: all five units offer at cycle 1 with rr_ptr=0.
  - Required: grants 0,1,2,3,4 on cycles 2–6; contention_cnt=4; rr_ptr wraps to 0.
- Fairness:
  - Stimulus: units 0 and 4 re-offer every cycle for 10 cycles.
  - Required: grants alternate 0,4,0,4…; neither unit waits more than 1 grant cycle.
- Backpressure:
  - Stimulus: units 1 and 3 both occupied with rr_ptr=3, and unit 1 offers a second result.
  - Required: fu_ready[1]=0 until unit 1 is granted; its first result appears unchanged, then its second result.
- Flush:
  - Stimulus: three buffers occupied, flush=1 for one cycle while unit 0 offers.
  - Required: cdb_valid=0 in the flush cycle; fu_ready[0]=1; all buffers empty next cycle; the dropped offer never appears on the CDB.
- Reset mid-stream:
  - Stimulus: rst=0 with two buffers occupied.
  - Required: fu_ready=0 and cdb_valid=0 during reset; afterward counters=0 and rr_ptr=0; the first new offer is granted with 1-cycle latency.
